// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read side: buffer FSM encoding,
// output buffer depth and the even-parity function used by the write side.
package async_fifo_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int BUF_DEPTH_C = 2;

    // Even parity bit: makes the total count of ones (data + bit) even.
    // Zero-extension to 64 bits leaves the result unchanged.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rd_skid_buffer.sv
// Two-entry head/tail output buffer with occupancy FSM (EMPTY/ONE/TWO).
// Ports: clk, rst (sync, active-high), push/push_data in, pop in,
//        head (oldest word), occupancy (0..2).
module rd_skid_buffer
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occupancy
);

    logic [1:0]       state;
    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (push) begin
                        head  <= push_data;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        tail  <= push_data;
                        state <= ST_TWO;
                    end else if (pop && !push) begin
                        state <= ST_EMPTY;
                    end else if (push && pop) begin
                        head  <= push_data;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head  <= tail;
                        state <= ST_ONE;
                        // Read issue logic never lets this happen;
                        // keep ordering intact if it ever does.
                        if (push) begin
                            tail  <= push_data;
                            state <= ST_TWO;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(state == ST_TWO && push && !pop))
                else $error("skid buffer overflow");
        end
    end

    assign occupancy = state;

endmodule

// File: rtl/fifo_read_stream_adapter.sv
// Async FIFO read port -> registered valid/ready stream, 1 word/cycle.
// Ports: rclk, rrst (sync, active-high), fifo_empty/fifo_ren/fifo_rdata
//        to the FIFO, m_valid/m_ready/m_data/m_perr to the sink, occupancy.
// Build option: FIFO_RD_PARITY_EN adds an even-parity MSB on fifo_rdata
// and drives m_perr; otherwise m_perr is tied to 0.
module fifo_read_stream_adapter
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
`ifdef FIFO_RD_PARITY_EN
    input  logic [DATA_WIDTH:0]   fifo_rdata,
`else
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
`endif
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_perr,
    output logic [1:0]            occupancy
);

    if (BUF_DEPTH != BUF_DEPTH_C) begin : g_depth_chk
        $error("BUF_DEPTH must be 2");
    end

    logic       inflight;
    logic       pop;
    logic [2:0] occ_sum;

    assign pop     = m_valid && m_ready;
    assign occ_sum = {1'b0, occupancy} + {2'b0, inflight};

    // Issue when a slot is free counting the word already in flight, or
    // when the buffer is full but its head leaves this cycle (m_ready path).
    assign fifo_ren = !rrst && !fifo_empty &&
                      ((occ_sum < 3'(BUF_DEPTH_C)) ||
                       (occ_sum == 3'(BUF_DEPTH_C) && pop));

    always_ff @(posedge rclk) begin
        if (rrst) inflight <= 1'b0;
        else      inflight <= fifo_ren;
    end

`ifdef FIFO_RD_PARITY_EN
    logic [DATA_WIDTH:0] push_word;
    logic [DATA_WIDTH:0] head;

    // Stored MSB becomes the error flag instead of the raw parity bit.
    assign push_word = {
        fifo_rdata[DATA_WIDTH] ^
            even_parity(64'(fifo_rdata[DATA_WIDTH-1:0])),
        fifo_rdata[DATA_WIDTH-1:0]
    };

    rd_skid_buffer #(.WIDTH(DATA_WIDTH + 1)) u_buf (
        .clk       (rclk),
        .rst       (rrst),
        .push      (inflight),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy)
    );

    assign m_data = head[DATA_WIDTH-1:0];
    assign m_perr = head[DATA_WIDTH];
`else
    rd_skid_buffer #(.WIDTH(DATA_WIDTH)) u_buf (
        .clk       (rclk),
        .rst       (rrst),
        .push      (inflight),
        .push_data (fifo_rdata),
        .pop       (pop),
        .head      (m_data),
        .occupancy (occupancy)
    );

    assign m_perr = 1'b0;
`endif

    assign m_valid = (occupancy != 2'd0);

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Self-checking bench for fifo_read_stream_adapter: FIFO source model,
// ordered scoreboard, directed scenarios and a random run.
module tb_fifo_read_stream_adapter;

`ifdef FIFO_RD_PARITY_EN
    localparam int RW = 9;
`else
    localparam int RW = 8;
`endif

    logic          rclk = 1'b0;
    logic          rrst;
    logic          fifo_empty;
    logic          fifo_ren;
    logic [RW-1:0] fifo_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [7:0]    m_data;
    logic          m_perr;
    logic [1:0]    occupancy;

    fifo_read_stream_adapter #(.DATA_WIDTH(8), .BUF_DEPTH(2)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_perr     (m_perr),
        .occupancy  (occupancy)
    );

    always #5 rclk = ~rclk;

    int vectors = 0;
    int errors  = 0;

    // Words are kept as {parity_bit, data}.
    logic [8:0] src[$];
    logic [8:0] expq[$];
    int         occ_m;
    logic       infl_m;
    logic       force_empty;
    logic       hold;
    logic [7:0] hold_data;
    logic       last_ren, last_valid;
    logic [7:0] last_data;
    int         reads;

    function automatic logic [8:0] mk(input logic [7:0] d, input logic ok);
        return {ok ? ^d : ~^d, d};
    endfunction

    function automatic logic exp_perr(input logic [8:0] w);
`ifdef FIFO_RD_PARITY_EN
        return w[8] ^ (^w[7:0]);
`else
        return 1'b0 & w[0];
`endif
    endfunction

    task automatic add_word(input logic [8:0] w);
        src.push_back(w);
        expq.push_back(w);
    endtask

    task automatic step();
        logic ren_s, pop_s, rst_s;
        logic [8:0] w;
        fifo_empty = force_empty || (src.size() == 0);
        @(negedge rclk);
        rst_s = rrst;
        ren_s = fifo_ren;
        pop_s = m_valid && m_ready;
        last_ren = fifo_ren;
        last_valid = m_valid;
        last_data = m_data;
        if (ren_s) reads++;
        vectors++;
        if (fifo_ren && (fifo_empty || rrst)) begin
            errors++;
            $display("FAIL ren_guard: fifo_ren=%0b empty=%0b rrst=%0b",
                     fifo_ren, fifo_empty, rrst);
        end
        vectors++;
        if (occupancy !== 2'(occ_m)) begin
            errors++;
            $display("FAIL occupancy: got %0d want %0d", occupancy, occ_m);
        end
        vectors++;
        if (m_valid !== (occ_m != 0)) begin
            errors++;
            $display("FAIL m_valid: got %0b want %0b", m_valid, occ_m != 0);
        end
        if (hold) begin
            vectors++;
            if (m_data !== hold_data) begin
                errors++;
                $display("FAIL stable: got %h want %h", m_data, hold_data);
            end
        end
        if (pop_s && !rst_s) begin
            vectors++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL extra_word: got %h want none", m_data);
            end else begin
                w = expq.pop_front();
                if (m_data !== w[7:0] || m_perr !== exp_perr(w)) begin
                    errors++;
                    $display("FAIL order: got %h/%0b want %h/%0b",
                             m_data, m_perr, w[7:0], exp_perr(w));
                end
            end
        end
        hold = m_valid && !m_ready && !rst_s;
        hold_data = m_data;
        @(posedge rclk);
        #1;
        if (rst_s) begin
            occ_m = 0;
            infl_m = 1'b0;
            expq = src;
            hold = 1'b0;
        end else begin
            occ_m = occ_m + int'(infl_m) - int'(pop_s);
            infl_m = ren_s;
            if (ren_s && src.size() != 0) begin
                w = src.pop_front();
                fifo_rdata = w[RW-1:0];
            end else begin
                fifo_rdata = RW'($urandom);
            end
        end
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget && expq.size() != 0; i++) step();
        vectors++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d left want 0", name, expq.size());
        end
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        m_ready = 1'b0;
        force_empty = 1'b0;
        fifo_rdata = '0;
        occ_m = 0;
        infl_m = 1'b0;
        hold = 1'b0;
        step();
        step();
        rrst = 1'b0;
        vectors++;
        if (m_valid !== 1'b0 || occupancy !== 2'd0 ||
            m_data !== 8'h00 || m_perr !== 1'b0) begin
            errors++;
            $display("FAIL reset: v=%0b occ=%0d d=%h p=%0b want 0/0/00/0",
                     m_valid, occupancy, m_data, m_perr);
        end
    endtask

    task automatic test_basic();
        logic [5:0] ren_pat, val_pat;
        logic [7:0] dat[3];
        ren_pat = 6'b000111;
        val_pat = 6'b011100;
        dat = '{8'h11, 8'h22, 8'h33};
        m_ready = 1'b1;
        add_word(mk(8'h11, 1'b1));
        add_word(mk(8'h22, 1'b1));
        add_word(mk(8'h33, 1'b1));
        for (int c = 0; c < 6; c++) begin
            step();
            vectors++;
            if (last_ren !== ren_pat[c] || last_valid !== val_pat[c]) begin
                errors++;
                $display("FAIL basic_c%0d: ren=%0b v=%0b want %0b/%0b",
                         c, last_ren, last_valid, ren_pat[c], val_pat[c]);
            end
            if (c >= 2 && c <= 4) begin
                vectors++;
                if (last_data !== dat[c-2]) begin
                    errors++;
                    $display("FAIL basic_data%0d: got %h want %h",
                             c, last_data, dat[c-2]);
                end
            end
        end
    endtask

    task automatic test_stall();
        m_ready = 1'b0;
        reads = 0;
        for (int i = 0; i < 5; i++) add_word(mk(8'(8'h40 + i), 1'b1));
        repeat (6) step();
        vectors++;
        if (reads != 2 || occupancy !== 2'd2 || last_ren !== 1'b0) begin
            errors++;
            $display("FAIL stall: reads=%0d occ=%0d ren=%0b want 2/2/0",
                     reads, occupancy, last_ren);
        end
        m_ready = 1'b1;
        drain(20, "stall");
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 20; i++) add_word(mk(8'($urandom), 1'b1));
        m_ready = 1'b1;
        for (int i = 0; i < 100 && expq.size() != 0; i++) begin
            step();
            m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        drain(10, "toggle");
    endtask

    task automatic test_empty_inflight();
        logic seen;
        seen = 1'b0;
        m_ready = 1'b1;
        reads = 0;
        add_word(mk(8'hA5, 1'b1));
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_valid && last_data == 8'hA5) seen = 1'b1;
        end
        vectors++;
        if (!seen || reads != 1 || expq.size() != 0) begin
            errors++;
            $display("FAIL empty_inflight: seen=%0b reads=%0d want 1/1",
                     seen, reads);
        end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) add_word(mk(8'(8'h60 + i), 1'b1));
        repeat (4) step();
        rrst = 1'b1;
        step();
        rrst = 1'b0;
        vectors++;
        if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL rst_full: v=%0b occ=%0d want 0/0",
                     m_valid, occupancy);
        end
        m_ready = 1'b1;
        drain(20, "rst_full");
        // Reset with one word buffered and one returning from storage.
        m_ready = 1'b0;
        add_word(mk(8'h71, 1'b1));
        add_word(mk(8'h72, 1'b1));
        step();
        step();
        rrst = 1'b1;
        step();
        rrst = 1'b0;
        vectors++;
        if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL rst_infl: v=%0b occ=%0d want 0/0",
                     m_valid, occupancy);
        end
        m_ready = 1'b1;
        repeat (5) step();
        vectors++;
        if (last_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_infl_drop: v=%0b want 0", last_valid);
        end
    endtask

`ifdef FIFO_RD_PARITY_EN
    task automatic test_parity();
        m_ready = 1'b0;
        add_word({1'b1, 8'h03});
        add_word({1'b0, 8'h03});
        for (int i = 0; i < 10 && occupancy != 2'd2; i++) step();
        vectors++;
        if (m_data !== 8'h03 || m_perr !== 1'b1) begin
            errors++;
            $display("FAIL parity_bad: d=%h p=%0b want 03/1", m_data, m_perr);
        end
        m_ready = 1'b1;
        step();
        vectors++;
        if (m_data !== 8'h03 || m_perr !== 1'b0) begin
            errors++;
            $display("FAIL parity_ok: d=%h p=%0b want 03/0", m_data, m_perr);
        end
        drain(10, "parity");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1, 0) == 1)
                add_word(mk(8'($urandom), $urandom_range(3, 0) != 0));
            m_ready = ($urandom_range(3, 0) != 0);
            force_empty = ($urandom_range(7, 0) == 0);
            step();
        end
        force_empty = 1'b0;
        m_ready = 1'b1;
        drain(1000, "random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_toggle();
        test_empty_inflight();
        test_reset_mid();
`ifdef FIFO_RD_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
